// File: rtl/program_bank_ctrl.sv
// Double-buffered instruction memory for the fetch/decode stage.
// The host loads the shadow bank while fetch reads the active bank; a committed swap is tick-aligned and drains the pipeline first.
module program_bank_ctrl #(
  parameter int unsigned n_blocks      = 256,
  parameter int unsigned drain_timeout = 64,
  localparam int unsigned AW = $clog2(n_blocks),
  localparam int unsigned CW = $clog2(drain_timeout + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_tick,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  input  logic          commit_req,
  input  logic [AW-1:0] commit_n_blocks,
  output logic          commit_ack,
  output logic          commit_forced,
  input  logic          pipe_idle,
  input  logic [AW-1:0] fetch_read_addr,
  output logic [31:0]   fetch_read_val,
  output logic          fetch_enable,
  output logic          fetch_reset,
  output logic [AW-1:0] n_blocks_running,
  output logic [AW-1:0] last_block,
  output logic          active_bank
);

  localparam int unsigned DEPTH = 2 * n_blocks;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN,
    ST_SWAP,
    ST_RESTART
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pending_n_q, pending_n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          forced_q, forced_d;
  logic          active_bank_q, active_bank_d;
  logic [AW-1:0] n_running_q, n_running_d;
  logic [AW-1:0] last_block_q, last_block_d;
  logic          fetch_enable_q, fetch_enable_d;
  logic          fetch_reset_q, fetch_reset_d;
  logic          commit_ack_q, commit_ack_d;
  logic          commit_forced_q, commit_forced_d;
  logic          wr_ready_q, wr_ready_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_val_q;

  // Next-state and registered-output logic; actions take effect when a state is left.
  always_comb begin
    state_d         = state_q;
    pending_n_d     = pending_n_q;
    cnt_d           = cnt_q;
    forced_d        = forced_q;
    active_bank_d   = active_bank_q;
    n_running_d     = n_running_q;
    last_block_d    = last_block_q;
    fetch_enable_d  = fetch_enable_q;
    fetch_reset_d   = fetch_reset_q;
    commit_ack_d    = 1'b0;
    commit_forced_d = commit_forced_q;

    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d     = ST_ARMED;
          pending_n_d = commit_n_blocks;
        end
      end
      ST_ARMED: begin
        if (!commit_req) begin
          state_d = ST_IDLE;
        end else if (sample_tick) begin
          state_d        = ST_DRAIN;
          fetch_enable_d = 1'b0;
          cnt_d          = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (pipe_idle) begin
          state_d  = ST_SWAP;
          forced_d = 1'b0;
        end else if (cnt_q == CW'(drain_timeout - 1)) begin
          // Counter reaches drain_timeout on this cycle: give up waiting.
          state_d  = ST_SWAP;
          forced_d = 1'b1;
        end
      end
      ST_SWAP: begin
        state_d         = ST_RESTART;
        active_bank_d   = ~active_bank_q;
        n_running_d     = pending_n_q;
        last_block_d    = (pending_n_q == '0) ? '0 : pending_n_q - AW'(1);
        fetch_reset_d   = 1'b1;
        commit_forced_d = forced_q;
      end
      ST_RESTART: begin
        state_d        = ST_IDLE;
        fetch_reset_d  = 1'b0;
        fetch_enable_d = 1'b1;
        commit_ack_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pending_n_q     <= '0;
      cnt_q           <= '0;
      forced_q        <= 1'b0;
      active_bank_q   <= 1'b0;
      n_running_q     <= '0;
      last_block_q    <= '0;
      fetch_enable_q  <= 1'b1;
      fetch_reset_q   <= 1'b0;
      commit_ack_q    <= 1'b0;
      commit_forced_q <= 1'b0;
      wr_ready_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      pending_n_q     <= pending_n_d;
      cnt_q           <= cnt_d;
      forced_q        <= forced_d;
      active_bank_q   <= active_bank_d;
      n_running_q     <= n_running_d;
      last_block_q    <= last_block_d;
      fetch_enable_q  <= fetch_enable_d;
      fetch_reset_q   <= fetch_reset_d;
      commit_ack_q    <= commit_ack_d;
      commit_forced_q <= commit_forced_d;
      wr_ready_q      <= wr_ready_d;
    end
  end

  // Banked RAM: host writes the shadow half, fetch reads the active half every cycle.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready_q) begin
      mem[{~active_bank_q, wr_addr}] <= wr_data;
    end
    rd_val_q <= mem[{active_bank_q, fetch_read_addr}];
  end

  assign wr_ready         = wr_ready_q;
  assign commit_ack       = commit_ack_q;
  assign commit_forced    = commit_forced_q;
  assign fetch_read_val   = rd_val_q;
  assign fetch_enable     = fetch_enable_q;
  assign fetch_reset      = fetch_reset_q;
  assign n_blocks_running = n_running_q;
  assign last_block       = last_block_q;
  assign active_bank      = active_bank_q;

endmodule

// File: tb/tb_program_bank_ctrl.sv
// Directed bench for program_bank_ctrl: swap sequencing, forced drain, cancel, dropped writes, reset.
module tb_program_bank_ctrl;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          commit_req;
  logic [AW-1:0] commit_n_blocks;
  logic          commit_ack;
  logic          commit_forced;
  logic          pipe_idle;
  logic [AW-1:0] fetch_read_addr;
  logic [31:0]   fetch_read_val;
  logic          fetch_enable;
  logic          fetch_reset;
  logic [AW-1:0] n_blocks_running;
  logic [AW-1:0] last_block;
  logic          active_bank;

  int checks = 0;
  int errors = 0;

  program_bank_ctrl #(.n_blocks(256), .drain_timeout(64)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .commit_req(commit_req), .commit_n_blocks(commit_n_blocks),
    .commit_ack(commit_ack), .commit_forced(commit_forced),
    .pipe_idle(pipe_idle), .fetch_read_addr(fetch_read_addr),
    .fetch_read_val(fetch_read_val), .fetch_enable(fetch_enable),
    .fetch_reset(fetch_reset), .n_blocks_running(n_blocks_running),
    .last_block(last_block), .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Request a commit and deliver the aligning tick; returns with the DUT just in DRAIN.
  task automatic arm(input logic [AW-1:0] n);
    commit_req = 1'b1; commit_n_blocks = n;
    tick();
    sample_tick = 1'b1;
    tick();
    sample_tick = 1'b0; commit_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %b exp 0", active_bank); end
    checks++; if (n_blocks_running !== 8'd0) begin errors++; $display("FAIL reset_nblk got %0d exp 0", n_blocks_running); end
    checks++; if (last_block !== 8'd0) begin errors++; $display("FAIL reset_last got %0d exp 0", last_block); end
    checks++; if ({fetch_enable, fetch_reset, commit_ack, commit_forced, wr_ready} !== 5'b10001) begin
      errors++; $display("FAIL reset_flags got %b exp 10001", {fetch_enable, fetch_reset, commit_ack, commit_forced, wr_ready});
    end
  endtask

  task automatic test_basic_swap();
    for (int i = 0; i < 4; i++) host_write(AW'(i), 32'hA000_0000 + 32'(i));
    commit_req = 1'b1; commit_n_blocks = 8'd4;
    tick();
    tick(); tick(); tick();
    checks++; if (fetch_enable !== 1'b1) begin errors++; $display("FAIL armed_enable got %b exp 1", fetch_enable); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL armed_wr_ready got %b exp 0", wr_ready); end
    sample_tick = 1'b1; pipe_idle = 1'b1;
    tick();
    sample_tick = 1'b0; commit_req = 1'b0;
    checks++; if ({fetch_enable, active_bank} !== 2'b00) begin errors++; $display("FAIL drain_entry got %b exp 00", {fetch_enable, active_bank}); end
    tick();
    checks++; if ({fetch_enable, fetch_reset} !== 2'b00) begin errors++; $display("FAIL swap_state got %b exp 00", {fetch_enable, fetch_reset}); end
    tick();
    checks++; if ({fetch_enable, fetch_reset, commit_ack, active_bank} !== 4'b0101) begin
      errors++; $display("FAIL restart_flags got %b exp 0101", {fetch_enable, fetch_reset, commit_ack, active_bank});
    end
    checks++; if (n_blocks_running !== 8'd4) begin errors++; $display("FAIL basic_nblk got %0d exp 4", n_blocks_running); end
    checks++; if (last_block !== 8'd3) begin errors++; $display("FAIL basic_last got %0d exp 3", last_block); end
    tick();
    checks++; if ({fetch_enable, fetch_reset, commit_ack} !== 3'b101) begin
      errors++; $display("FAIL ack_flags got %b exp 101", {fetch_enable, fetch_reset, commit_ack});
    end
    tick();
    checks++; if ({commit_ack, wr_ready, commit_forced} !== 3'b010) begin
      errors++; $display("FAIL post_ack got %b exp 010", {commit_ack, wr_ready, commit_forced});
    end
  endtask

  task automatic test_read_no_alias();
    fetch_read_addr = 8'd2;
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    checks++; if (fetch_read_val !== 32'hA000_0002) begin errors++; $display("FAIL read_active2 got %h exp a0000002", fetch_read_val); end
    fetch_read_addr = 8'd0;
    tick();
    checks++; if (fetch_read_val !== 32'hA000_0000) begin errors++; $display("FAIL read_active0 got %h exp a0000000", fetch_read_val); end
    fetch_read_addr = 8'd3;
    tick();
    checks++; if (fetch_read_val !== 32'hA000_0003) begin errors++; $display("FAIL read_active3 got %h exp a0000003", fetch_read_val); end
  endtask

  task automatic test_forced_drain();
    int cyc = 0;
    int low = 0;
    pipe_idle = 1'b0;
    arm(8'd8);
    while (fetch_reset !== 1'b1 && cyc < 200) begin
      if (fetch_enable === 1'b0) low++;
      tick();
      cyc++;
    end
    checks++; if (cyc != 65) begin errors++; $display("FAIL forced_latency got %0d exp 65", cyc); end
    checks++; if (low != 65) begin errors++; $display("FAIL forced_enable_low got %0d exp 65", low); end
    checks++; if ({commit_forced, active_bank, fetch_enable} !== 3'b100) begin
      errors++; $display("FAIL forced_flags got %b exp 100", {commit_forced, active_bank, fetch_enable});
    end
    checks++; if (last_block !== 8'd7) begin errors++; $display("FAIL forced_last got %0d exp 7", last_block); end
    tick();
    checks++; if ({commit_ack, fetch_enable} !== 2'b11) begin errors++; $display("FAIL forced_ack got %b exp 11", {commit_ack, fetch_enable}); end
    fetch_read_addr = 8'd2;
    tick();
    checks++; if (fetch_read_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shadow_write got %h exp deadbeef", fetch_read_val); end
    pipe_idle = 1'b1;
    arm(8'd5);
    tick();
    checks++; if (commit_forced !== 1'b1) begin errors++; $display("FAIL forced_hold got %b exp 1", commit_forced); end
    tick();
    checks++; if ({commit_forced, active_bank} !== 2'b01) begin errors++; $display("FAIL forced_clear got %b exp 01", {commit_forced, active_bank}); end
    checks++; if (last_block !== 8'd4) begin errors++; $display("FAIL clean_last got %0d exp 4", last_block); end
    tick(); tick();
  endtask

  task automatic test_cancel();
    int acks = 0;
    commit_req = 1'b1; commit_n_blocks = 8'd9;
    tick(); tick();
    commit_req = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL cancel_idle got %b exp 1", wr_ready); end
    sample_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sample_tick = 1'b0;
      if (commit_ack !== 1'b0 || fetch_enable !== 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL cancel_activity got %0d exp 0", acks); end
    checks++; if ({active_bank, n_blocks_running} !== {1'b1, 8'd5}) begin
      errors++; $display("FAIL cancel_state got %b/%0d exp 1/5", active_bank, n_blocks_running);
    end
  endtask

  task automatic test_drain_write();
    pipe_idle = 1'b0;
    commit_req = 1'b1; commit_n_blocks = 8'd6; sample_tick = 1'b1;
    tick();
    sample_tick = 1'b0;
    tick();
    checks++; if (fetch_enable !== 1'b1) begin errors++; $display("FAIL entry_tick_counted got %b exp 1", fetch_enable); end
    sample_tick = 1'b1;
    tick();
    sample_tick = 1'b0; commit_req = 1'b0;
    checks++; if ({wr_ready, fetch_enable} !== 2'b00) begin errors++; $display("FAIL drain_wr_ready got %b exp 00", {wr_ready, fetch_enable}); end
    host_write(8'd2, 32'hBAD0_BAD0);
    pipe_idle = 1'b1;
    tick(); tick(); tick();
    checks++; if ({commit_ack, active_bank, n_blocks_running} !== {2'b10, 8'd6}) begin
      errors++; $display("FAIL drain_swap got %b/%b/%0d exp 1/0/6", commit_ack, active_bank, n_blocks_running);
    end
    fetch_read_addr = 8'd2;
    tick();
    checks++; if (fetch_read_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dropped_write got %h exp deadbeef", fetch_read_val); end
  endtask

  task automatic test_zero_and_reset();
    int acks = 0;
    pipe_idle = 1'b1;
    arm(8'd0);
    tick(); tick();
    checks++; if ({active_bank, n_blocks_running, last_block} !== {1'b1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL zero_commit got %b/%0d/%0d exp 1/0/0", active_bank, n_blocks_running, last_block);
    end
    tick(); tick();
    pipe_idle = 1'b0;
    arm(8'd7);
    tick(); tick();
    checks++; if (fetch_enable !== 1'b0) begin errors++; $display("FAIL pre_reset_drain got %b exp 0", fetch_enable); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({active_bank, fetch_enable, fetch_reset, wr_ready, commit_forced} !== 5'b01010) begin
      errors++; $display("FAIL midswap_reset got %b exp 01010", {active_bank, fetch_enable, fetch_reset, wr_ready, commit_forced});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (commit_ack !== 1'b0 || active_bank !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL midswap_no_ack got %0d exp 0", acks); end
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; commit_n_blocks = '0; pipe_idle = 1'b0; fetch_read_addr = '0;
    test_reset();
    test_basic_swap();
    test_read_no_alias();
    test_forced_drain();
    test_cancel();
    test_drain_write();
    test_zero_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
